prim_and2_rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single registered AND-mask datapath (`out = data & mask`, bitwise, built from the generic `and2` primitive) among `N` requesters. One requester is granted per cycle. Its data/mask pair is combined and captured into a one-entry output register, which is drained through a valid/ready handshake. It sits between several masking clients, such as CSR write-mask or byte-enable merge sources, and the single downstream consumer of masked words.

---
 rtl/prim_and2_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_prim_and2_rr_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/prim_and2_rr_arbiter.sv
// prim_and2_rr_arbiter
//   Round-robin arbiter in front of one registered AND-mask stage. Each cycle
//   the output register can load, one requester is granted. Its data & mask
//   is captured into a one-entry output register, which is drained by a
//   valid/ready handshake.
//
// Ports
//   clk_i    in   1        clock, rising edge
//   rst_i    in   1        asynchronous active-high reset
//   req_i    in   N        per-requester request, level-held until granted
//   data_i   in   N*Width  requester k data at [k*Width +: Width]
//   mask_i   in   N*Width  requester k mask, same packing
//   gnt_o    out  N        one-hot combinational grant (zero while stalled)
//   valid_o  out  1        output register holds a result
//   ready_i  in   1        consumer takes out_o when valid_o & ready_i
//   out_o    out  Width    registered data & mask of the granted requester
//   idx_o    out  IdxW     requester index of the result in out_o

// Generic two-input AND primitive; the masking datapath is an array of these.
module prim_and2 (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);
   assign y_o = a_i & b_i;
endmodule

module prim_and2_rr_arbiter #(
   parameter int N     = 4,
   parameter int Width = 32,
   parameter int IdxW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req_i,
   input  logic [N*Width-1:0]   data_i,
   input  logic [N*Width-1:0]   mask_i,
   output logic [N-1:0]         gnt_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [Width-1:0]     out_o,
   output logic [IdxW-1:0]      idx_o
);

   logic                      r_valid;
   logic [Width-1:0]          r_out;
   logic [IdxW-1:0]           r_idx;
   logic [IdxW-1:0]           r_ptr;

   logic                      w_can_load;
   logic                      w_any;
   logic [IdxW-1:0]           w_idx;
   logic [N-1:0]              w_gnt;
   logic [N-1:0][Width-1:0]   w_data;
   logic [N-1:0][Width-1:0]   w_mask;
   logic [Width-1:0]          w_sel_data;
   logic [Width-1:0]          w_sel_mask;
   logic [Width-1:0]          w_and;

   // Register is empty or is being drained on this edge.
   assign w_can_load = !r_valid | ready_i;

   // Scan from r_ptr upward with explicit modulo-N wrap. The loop runs from
   // the farthest offset down so the closest requester to r_ptr wins.
   always_comb begin
      int j;
      j     = 0;
      w_any = 1'b0;
      w_idx = '0;
      for (int i = N-1; i >= 0; i--) begin
         j = int'(r_ptr) + i;
         if (j >= N) j = j - N;
         if (req_i[j]) begin
            w_any = 1'b1;
            w_idx = IdxW'(j);
         end
      end
   end

   always_comb begin
      w_gnt = '0;
      if (w_can_load && w_any) w_gnt[w_idx] = 1'b1;
   end

   assign w_data     = data_i;
   assign w_mask     = mask_i;
   assign w_sel_data = w_data[w_idx];
   assign w_sel_mask = w_mask[w_idx];

   for (genvar b = 0; b < Width; b++) begin : g_and
      prim_and2 u_and2 (
         .a_i (w_sel_data[b]),
         .b_i (w_sel_mask[b]),
         .y_o (w_and[b])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_out   <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
      end else if (w_can_load) begin
         if (w_any) begin
            r_valid <= 1'b1;
            r_out   <= w_and;
            r_idx   <= w_idx;
            // N need not be a power of two, so wrap explicitly.
            r_ptr   <= (w_idx == IdxW'(N-1)) ? '0 : w_idx + 1'b1;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign gnt_o   = w_gnt;
   assign valid_o = r_valid;
   assign out_o   = r_out;
   assign idx_o   = r_idx;

endmodule

// File: tb/tb_prim_and2_rr_arbiter.sv
module tb_prim_and2_rr_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   // N=4, Width=32 instance
   logic [3:0]    req;
   logic [127:0]  data, mask;
   logic [3:0]    gnt;
   logic          valid, rdy;
   logic [31:0]   out;
   logic [1:0]    idx;
   // N=3, Width=8 instance
   logic [2:0]    req3;
   logic [23:0]   data3, mask3;
   logic [2:0]    gnt3;
   logic          valid3, rdy3;
   logic [7:0]    out3;
   logic [1:0]    idx3;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  i;
   } exp_t;
   exp_t sbq[$];

   // Hand-computed data & mask per requester.
   logic [31:0] exp_res [4];

   always #5 clk = ~clk;

   prim_and2_rr_arbiter #(.N(4), .Width(32)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .mask_i(mask),
      .gnt_o(gnt), .valid_o(valid), .ready_i(rdy), .out_o(out), .idx_o(idx)
   );

   prim_and2_rr_arbiter #(.N(3), .Width(8)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .req_i(req3), .data_i(data3), .mask_i(mask3),
      .gnt_o(gnt3), .valid_o(valid3), .ready_i(rdy3), .out_o(out3), .idx_o(idx3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive after the rising edge, return at the falling edge for checking.
   task automatic cyc(input logic [3:0] r, input logic rd);
      @(posedge clk); #1;
      req = r; rdy = rd;
      @(negedge clk);
   endtask

   task automatic cyc3(input logic [2:0] r);
      @(posedge clk); #1;
      req3 = r; rdy3 = 1'b1;
      @(negedge clk);
   endtask

   task automatic push(input int k);
      exp_t e;
      e.d = exp_res[k];
      e.i = 2'(k);
      sbq.push_back(e);
   endtask

   // Monitor: every accepted result is compared against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && valid && rdy) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_result", {30'd0, idx}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_out", out, e.d);
               chk("sb_idx", {30'd0, idx}, {30'd0, e.i});
            end
         end
      end
   end

   initial begin
      exp_res[0] = 32'h1234_0000;   // 1234_5678 & FFFF_0000
      exp_res[1] = 32'h0505_0505;   // A5A5_A5A5 & 0F0F_0F0F
      exp_res[2] = 32'h0E0D_BE00;   // DEAD_BEEF & 0F0F_FF00
      exp_res[3] = 32'hCA00_000D;   // CAFE_F00D & FF00_00FF
      data = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h1234_5678};
      mask = {32'hFF00_00FF, 32'h0F0F_FF00, 32'h0F0F_0F0F, 32'hFFFF_0000};
      data3 = {8'hAA, 8'h3C, 8'hF0};
      mask3 = {8'hF0, 8'h0F, 8'hFF};   // results F0, 0C, A0
      req = '0; rdy = 1'b1; req3 = '0; rdy3 = 1'b1;
      rst = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_out",   out, 32'd0);
      chk("rst_idx",   {30'd0, idx}, 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Masking: single requester 2
      cyc(4'b0100, 1'b1);
      chk("mask_gnt", {28'd0, gnt}, 32'h4);
      push(2);
      cyc(4'b0000, 1'b1);
      chk("mask_valid", {31'd0, valid}, 32'd1);
      chk("mask_idle_gnt", {28'd0, gnt}, 32'h0);
      cyc(4'b0000, 1'b1);
      chk("mask_drained", {31'd0, valid}, 32'd0);

      // Mid-stream reset: load requester 3 and hold it with ready low,
      // then discard it through reset.
      cyc(4'b1000, 1'b0);
      chk("pre_rst_gnt", {28'd0, gnt}, 32'h8);
      @(posedge clk); #1; req = '0; rdy = 1'b0;
      #1;
      chk("pre_rst_valid", {31'd0, valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, valid}, 32'd0);
      chk("midrst_out",   out, 32'd0);
      chk("midrst_idx",   {30'd0, idx}, 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      cyc(4'b1010, 1'b1);
      chk("post_rst_gnt", {28'd0, gnt}, 32'h2);
      push(1);

      // Round-robin with wrap: pointer is at 2, all requesting.
      cyc(4'b1111, 1'b1); chk("rr_gnt0", {28'd0, gnt}, 32'h4); chk("rr_valid0", {31'd0, valid}, 32'd1); push(2);
      cyc(4'b1111, 1'b1); chk("rr_gnt1", {28'd0, gnt}, 32'h8); chk("rr_valid1", {31'd0, valid}, 32'd1); push(3);
      cyc(4'b1111, 1'b1); chk("rr_gnt2", {28'd0, gnt}, 32'h1); chk("rr_valid2", {31'd0, valid}, 32'd1); push(0);
      cyc(4'b1111, 1'b1); chk("rr_gnt3", {28'd0, gnt}, 32'h2); chk("rr_valid3", {31'd0, valid}, 32'd1); push(1);
      cyc(4'b1111, 1'b1); chk("rr_gnt4", {28'd0, gnt}, 32'h4); chk("rr_valid4", {31'd0, valid}, 32'd1); push(2);
      cyc(4'b1111, 1'b1); chk("rr_gnt5", {28'd0, gnt}, 32'h8); chk("rr_valid5", {31'd0, valid}, 32'd1); push(3);

      // Back-pressure with a request from requester 1 that drops before
      // ready returns. Pointer sits at 0; requester 3's result is held.
      cyc(4'b0000, 1'b0);
      chk("bp_gnt0", {28'd0, gnt}, 32'h0); chk("bp_idx0", {30'd0, idx}, 32'd3); chk("bp_out0", out, 32'hCA00_000D);
      cyc(4'b0010, 1'b0);
      chk("bp_gnt1", {28'd0, gnt}, 32'h0); chk("bp_idx1", {30'd0, idx}, 32'd3); chk("bp_out1", out, 32'hCA00_000D);
      cyc(4'b0010, 1'b0);
      chk("bp_gnt2", {28'd0, gnt}, 32'h0); chk("bp_idx2", {30'd0, idx}, 32'd3); chk("bp_valid2", {31'd0, valid}, 32'd1);
      cyc(4'b0100, 1'b1);
      chk("bp_release_gnt", {28'd0, gnt}, 32'h4);
      push(2);
      cyc(4'b0000, 1'b1);
      chk("bp_no_bubble", {31'd0, valid}, 32'd1);
      cyc(4'b0000, 1'b1);
      chk("bp_drained", {31'd0, valid}, 32'd0);
      chk("sb_empty", sbq.size(), 32'd0);

      // Non-power-of-two N=3: 0,1,2,0 with wrap at 2.
      cyc3(3'b111); chk("n3_gnt0", {29'd0, gnt3}, 32'h1);
      cyc3(3'b111); chk("n3_gnt1", {29'd0, gnt3}, 32'h2); chk("n3_idx0", {30'd0, idx3}, 32'd0); chk("n3_out0", {24'd0, out3}, 32'hF0);
      cyc3(3'b111); chk("n3_gnt2", {29'd0, gnt3}, 32'h4); chk("n3_idx1", {30'd0, idx3}, 32'd1); chk("n3_out1", {24'd0, out3}, 32'h0C);
      cyc3(3'b111); chk("n3_gnt3", {29'd0, gnt3}, 32'h1); chk("n3_idx2", {30'd0, idx3}, 32'd2); chk("n3_out2", {24'd0, out3}, 32'hA0);
      cyc3(3'b000); chk("n3_idx3", {30'd0, idx3}, 32'd0); chk("n3_valid3", {31'd0, valid3}, 32'd1);
      cyc3(3'b000); chk("n3_drained", {31'd0, valid3}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
